mio_arbiter: RTL and testbench

- Two-master arbiter and sequencer in front of the memory-mapped I/O bus decoder.
- Shares one bus between master 0 (CPU data port) and master 1 (note/VRAM DMA engine).
- Issues exactly one transaction at a time with a 1-cycle write strobe and fixed read latency.
- Filters illegal accesses (unmapped regions, writes to read-only regions) before they reach the bus.

---
 rtl/mio_pkg.sv | 39 +++
 rtl/mio_rr_pick.sv | 23 ++
 rtl/mio_arbiter.sv | 155 +++++++++++++++
 tb/tb_mio_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MMIO arbiter: region map, access rights, FSM encoding.
package mio_pkg;

    localparam logic [3:0] REG_RAM   = 4'h0;
    localparam logic [3:0] REG_CNT   = 4'h1;
    localparam logic [3:0] REG_PITCH = 4'h2;
    localparam logic [3:0] REG_VRAM  = 4'hC;
    localparam logic [3:0] REG_PS2   = 4'hD;
    localparam logic [3:0] REG_GPIO  = 4'hE;
    localparam logic [3:0] REG_SW    = 4'hF;

    // Read latency is 0..3, so a 2-bit down-counter suffices.
    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {AccNone, AccRo, AccWo, AccRw} acc_e;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    function automatic acc_e region_acc(input logic [3:0] region);
        acc_e acc;
        acc = AccNone;
        case (region)
            REG_RAM:                     acc = AccRw;
            REG_CNT, REG_PS2, REG_SW:    acc = AccRo;
            REG_PITCH, REG_VRAM, REG_GPIO: acc = AccWo;
            default:                     acc = AccNone;
        endcase
        return acc;
    endfunction

    // Reads from write-only regions are allowed; they just return whatever the bus drives.
    function automatic logic access_illegal(input logic [3:0] region, input logic we);
        acc_e acc;
        acc = region_acc(region);
        return (acc == AccNone) || (we && (acc == AccRo));
    endfunction

endpackage

// File: rtl/mio_rr_pick.sv
// Two-way request picker. Round-robin on ties unless MIO_ARB_CPU_PRIORITY_EN is defined,
// in which case master 0 always wins a tie.
module mio_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        valid = req0 | req1;
`ifdef MIO_ARB_CPU_PRIORITY_EN
        winner = ~req0;
`else
        winner = (req0 & req1) ? ~last_grant : req1;
`endif
    end

endmodule

// File: rtl/mio_arbiter.sv
// Two-master MMIO arbiter/sequencer: one transaction at a time, access filtering, fixed read
// latency. Define MIO_ARB_CPU_PRIORITY_EN to give master 0 fixed priority on ties.
module mio_arbiter
    import mio_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        bus_mem_w,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        grant,
    output logic        busy
);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_q, grant_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic               m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic               pick_valid, pick_winner;
    logic [31:0]        done_rdata;

    mio_rr_pick u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            illegal_q    <= 1'b0;
            cnt_q        <= '0;
            m0_rdata_q   <= '0;
            m0_err_q     <= 1'b0;
            m1_rdata_q   <= '0;
            m1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            illegal_q    <= illegal_d;
            cnt_q        <= cnt_d;
            m0_rdata_q   <= m0_rdata_d;
            m0_err_q     <= m0_err_d;
            m1_rdata_q   <= m1_rdata_d;
            m1_err_q     <= m1_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (pick_valid) state_d = StAccess;
            StAccess: if (illegal_q || we_q || (cnt_q == '0)) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Writes and illegal accesses complete with zero read data.
    assign done_rdata = (illegal_q || we_q) ? 32'h0 : bus_rdata;

    always_comb begin
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        illegal_d    = illegal_q;
        cnt_d        = cnt_q;
        m0_rdata_d   = m0_rdata_q;
        m0_err_d     = m0_err_q;
        m1_rdata_d   = m1_rdata_q;
        m1_err_d     = m1_err_q;
        if ((state_q == StIdle) && pick_valid) begin
            grant_d      = pick_winner;
            last_grant_d = pick_winner;
            we_d         = pick_winner ? m1_we : m0_we;
            addr_d       = pick_winner ? m1_addr : m0_addr;
            wdata_d      = pick_winner ? m1_wdata : m0_wdata;
            illegal_d    = access_illegal(addr_d[31:28], we_d);
            cnt_d        = CNT_W'(RD_LATENCY);
        end else if (state_q == StAccess) begin
            if (state_d == StDone) begin
                if (grant_q) begin
                    m1_rdata_d = done_rdata;
                    m1_err_d   = illegal_q;
                end else begin
                    m0_rdata_d = done_rdata;
                    m0_err_d   = illegal_q;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        bus_mem_w = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        if ((state_q == StAccess) && !illegal_q) begin
            bus_mem_w = we_q;
            bus_addr  = addr_q;
            bus_wdata = wdata_q;
        end
        if (state_q == StDone) begin
            m0_ack = ~grant_q;
            m1_ack = grant_q;
        end
    end

    assign busy     = (state_q != StIdle);
    assign grant    = grant_q;
    assign m0_rdata = m0_rdata_q;
    assign m0_err   = m0_err_q;
    assign m1_rdata = m1_rdata_q;
    assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter (RD_LATENCY=1): vector table plus tie, abort and drop sequences.
module tb_mio_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_mem_w, grant, busy;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mio_arbiter #(.RD_LATENCY(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .bus_mem_w (bus_mem_w),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .grant     (grant),
        .busy      (busy)
    );

    typedef struct {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rd;
        int          lat;
        int          mw;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr1;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns in an IDLE cycle, 1 time unit after its rising edge.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc, mw_cnt;
        logic        seen, other_ack, g1, err_s;
        logic [31:0] addr1, mw_addr, mw_wdata, rdata_s;
        wait_idle();
        if (v.m == 1'b0) begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end else begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end
        bus_rdata = v.bus_rd;
        cyc = 0; mw_cnt = 0; seen = 1'b0; other_ack = 1'b0; g1 = 1'b0;
        addr1 = '0; mw_addr = '0; mw_wdata = '0; err_s = 1'b0; rdata_s = '0;
        while (!seen && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                addr1 = bus_addr;
                g1    = grant;
            end
            if (bus_mem_w) begin
                mw_cnt++;
                mw_addr  = bus_addr;
                mw_wdata = bus_wdata;
            end
            if (v.m ? m0_ack : m1_ack) other_ack = 1'b1;
            if (v.m ? m1_ack : m0_ack) begin
                seen    = 1'b1;
                err_s   = v.m ? m1_err : m0_err;
                rdata_s = v.m ? m1_rdata : m0_rdata;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check($sformatf("v%0d_ack_cycle", idx), cyc, v.lat);
        check($sformatf("v%0d_grant", idx), {31'b0, g1}, {31'b0, v.m});
        check($sformatf("v%0d_bus_addr_c1", idx), addr1, v.addr1);
        check($sformatf("v%0d_mem_w_count", idx), mw_cnt, v.mw);
        check($sformatf("v%0d_err", idx), {31'b0, err_s}, {31'b0, v.err});
        check($sformatf("v%0d_rdata", idx), rdata_s, v.rdata);
        check($sformatf("v%0d_other_ack", idx), {31'b0, other_ack}, 32'h0);
        if (v.mw == 1) begin
            check($sformatf("v%0d_mw_addr", idx), mw_addr, v.addr);
            check($sformatf("v%0d_mw_wdata", idx), mw_wdata, v.wdata);
        end
    endtask

    int          cyc, acks_n, m0_n, m0_c, m1_c;
    int          ack_who[4];
    int          ack_cyc[4];
    int          exp_tie[4];
    logic        any_ack;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            m     we    addr          wdata         bus_rd        lat mw err  rdata         addr1
        vecs[0] = '{1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF, 32'h0,        2, 1, 1'b0, 32'h0,        32'h00000010};
        vecs[1] = '{1'b1, 1'b0, 32'hF0000000, 32'h0,        32'h0000A5A5, 3, 0, 1'b0, 32'h0000A5A5, 32'hF0000000};
        vecs[2] = '{1'b0, 1'b1, 32'hD0000000, 32'h12345678, 32'h0,        2, 0, 1'b1, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h50000000, 32'h0,        32'h12345678, 2, 0, 1'b1, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'hC0000123, 32'h00000077, 32'h0,        2, 1, 1'b0, 32'h0,        32'hC0000123};
        vecs[5] = '{1'b0, 1'b0, 32'h20000004, 32'h0,        32'hCAFEF00D, 3, 0, 1'b0, 32'hCAFEF00D, 32'h20000004};
        vecs[6] = '{1'b1, 1'b1, 32'h10000000, 32'h00000001, 32'h0,        2, 0, 1'b1, 32'h0,        32'h0};
        vecs[7] = '{1'b0, 1'b1, 32'hB0000000, 32'h00000002, 32'h0,        2, 0, 1'b1, 32'h0,        32'h0};
        vecs[8] = '{1'b1, 1'b1, 32'hE0000000, 32'h0000000F, 32'h0,        2, 1, 1'b0, 32'h0,        32'hE0000000};
        vecs[9] = '{1'b0, 1'b0, 32'h00000100, 32'h0,        32'h11112222, 3, 0, 1'b0, 32'h11112222, 32'h00000100};
`ifdef MIO_ARB_CPU_PRIORITY_EN
        exp_tie = '{0, 0, 0, 0};
`else
        exp_tie = '{0, 1, 0, 1};
`endif

        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        bus_rdata = '0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_mem_w", {31'b0, bus_mem_w}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_acks", {30'b0, m1_ack, m0_ack}, 32'h0);
        check("rst_grant", {31'b0, grant}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Abort an m0 read mid-ACCESS; m0_rdata still holds the last vector's data here.
        wait_idle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h00000200; bus_rdata = 32'h00000055;
        @(posedge clk); #1;
        check("abort_access_addr", bus_addr, 32'h00000200);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_bus_addr", bus_addr, 32'h0);
        check("abort_m0_rdata", m0_rdata, 32'h0);
        check("abort_grant", {31'b0, grant}, 32'h0);
        m0_req = 1'b0;
        any_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) any_ack = 1'b1;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack || busy) any_ack = 1'b1;
        end
        check("abort_no_ack", {31'b0, any_ack}, 32'h0);

        // Both masters hold req for four writes.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h00000004; m0_wdata = 32'hAAAA0000;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h00000008; m1_wdata = 32'hBBBB0000;
        acks_n = 0; cyc = 0;
        ack_who = '{-1, -1, -1, -1};
        ack_cyc = '{0, 0, 0, 0};
        while (acks_n < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (m0_ack) begin
                ack_who[acks_n] = 0; ack_cyc[acks_n] = cyc; acks_n++;
            end else if (m1_ack) begin
                ack_who[acks_n] = 1; ack_cyc[acks_n] = cyc; acks_n++;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("tie_count", acks_n, 4);
        for (int i = 0; i < 4; i++) check($sformatf("tie_winner%0d", i), ack_who[i], exp_tie[i]);
        check("tie_first_cycle", ack_cyc[0], 2);
        check("tie_last_cycle", ack_cyc[3], 11);

        // m0 drops req right after its grant; pending m1 is served next.
        wait_idle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h00000040;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h00000080;
        bus_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        check("drop_grant", {31'b0, grant}, 32'h0);
        m0_req = 1'b0;
        cyc = 1; m0_n = 0; m0_c = 0; m1_c = 0;
        while (m1_c == 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (m0_ack) begin
                m0_n++;
                m0_c = cyc;
            end
            if (m1_ack) m1_c = cyc;
        end
        m1_req = 1'b0;
        check("drop_m0_ack_count", m0_n, 1);
        check("drop_m0_ack_cycle", m0_c, 3);
        check("drop_m0_rdata", m0_rdata, 32'h0BADF00D);
        check("drop_m1_ack_cycle", m1_c, 7);
        check("drop_m1_rdata", m1_rdata, 32'h0BADF00D);
        check("drop_m1_err", {31'b0, m1_err}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
